mpc_boost_predictor: RTL and testbench

Front-end for the incremental-conductance MPC duty controller: captures a PV/output sample, predicts next-period inductor current for duty ±1 step with a discrete boost-converter model, then issues the calculate request to the controller. It waits for the controller's data-valid strobe and latches the returned duty cycle as the active PWM command. It is the initiating end of the calc/DV handshake; the controller is the responder.

---
 rtl/mpc_pkg.sv | 32 +++
 rtl/q16_mul.sv | 17 +
 rtl/mpc_boost_predictor.sv | 190 +++++++++++++++++++
 tb/tb_mpc_boost_predictor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
// Shared definitions for the MPC duty-control front end: Q16.16 constants,
// default plant/step coefficients and the common state encoding.
package mpc_pkg;

  localparam int                 Q_W                = 32;
  localparam logic signed [31:0] ONE                = 32'sh00010000;
  localparam logic signed [31:0] DUTY_INIT          = 32'sh00008000;
  localparam logic signed [31:0] DC_Z_DEFAULT       = 32'sh00000007;
  localparam logic signed [31:0] TS_OVER_L_DEFAULT  = 32'sh0000028F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COMP  = 3'd1,
    ST_MULT  = 3'd2,
    ST_SUB   = 3'd3,
    ST_SCALE = 3'd4,
    ST_ISSUE = 3'd5,
    ST_WAIT  = 3'd6
  } mpc_state_t;

  // Keeps a duty value inside the physically meaningful range [0, 1].
  function automatic logic signed [31:0] clamp_duty(input logic signed [31:0] d);
    if (d < 0) begin
      return '0;
    end else if (d > ONE) begin
      return ONE;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/q16_mul.sv
// Combinational signed Q16.16 multiply: full 64-bit product, floor shift by 16,
// low 32 bits kept (no saturation).
module q16_mul (
  input  logic signed [31:0] i_a,
  input  logic signed [31:0] i_b,
  output logic signed [31:0] o_p
);

  logic signed [63:0] prod;
  logic        [15:0] unused_hi;
  logic        [15:0] unused_lo;

  assign prod = i_a * i_b;
  // Bits [47:16] are exactly (prod >>> 16) truncated to 32 bits.
  assign {unused_hi, o_p, unused_lo} = prod;

endmodule

// File: rtl/mpc_boost_predictor.sv
// Boost-converter current predictor and calc/DV initiator for the MPC duty
// controller; owns the active PWM duty command.
module mpc_boost_predictor
  import mpc_pkg::*;
#(
  parameter logic signed [31:0] TS_OVER_L   = TS_OVER_L_DEFAULT,
  parameter logic signed [31:0] DC_Z        = DC_Z_DEFAULT,
  parameter int unsigned        TIMEOUT_CYC = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sample_valid,
  input  logic signed [31:0] i_Vpv,
  input  logic signed [31:0] i_Ipv,
  input  logic signed [31:0] i_Vout,
  output logic signed [31:0] o_Vpv,
  output logic signed [31:0] o_Ipv,
  output logic signed [31:0] o_Vout,
  output logic signed [31:0] o_Ipv_plus,
  output logic signed [31:0] o_Ipv_minus,
  output logic               o_calc_DV,
  input  logic signed [31:0] i_DC_control,
  input  logic               i_DV,
  output logic signed [31:0] o_duty,
  output logic               o_busy,
  output logic               o_drop,
  output logic               o_timeout
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mpc_state_t         state_q, state_d;
  logic signed [31:0] vpv_q, vpv_d, ipv_q, ipv_d, vout_q, vout_d;
  logic signed [31:0] ap_q, ap_d, am_q, am_d;
  logic signed [31:0] pp_q, pp_d, pm_q, pm_d;
  logic signed [31:0] ep_q, ep_d, em_q, em_d;
  logic signed [31:0] ipv_plus_q, ipv_plus_d, ipv_minus_q, ipv_minus_d;
  logic signed [31:0] duty_q, duty_d;
  logic               calc_q, calc_d, drop_q, drop_d, timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [31:0] dp_raw, dm_raw, dp, dm;
  logic signed [31:0] mul_a [4];
  logic signed [31:0] mul_b [4];
  logic signed [31:0] mul_p [4];

  assign dp_raw = duty_q + DC_Z;
  assign dm_raw = duty_q - DC_Z;
  assign dp     = (dp_raw > ONE) ? ONE : dp_raw;
  assign dm     = (dm_raw < 0) ? '0 : dm_raw;

  // Lanes 0/1 form (1-D)*Vout for MULT, lanes 2/3 form Ts/L*E for SCALE.
  always_comb begin
    mul_a[0] = ap_q;      mul_b[0] = vout_q;
    mul_a[1] = am_q;      mul_b[1] = vout_q;
    mul_a[2] = TS_OVER_L; mul_b[2] = ep_q;
    mul_a[3] = TS_OVER_L; mul_b[3] = em_q;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mul
      q16_mul u_mul (
        .i_a (mul_a[gi]),
        .i_b (mul_b[gi]),
        .o_p (mul_p[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    vpv_d       = vpv_q;
    ipv_d       = ipv_q;
    vout_d      = vout_q;
    ap_d        = ap_q;
    am_d        = am_q;
    pp_d        = pp_q;
    pm_d        = pm_q;
    ep_d        = ep_q;
    em_d        = em_q;
    ipv_plus_d  = ipv_plus_q;
    ipv_minus_d = ipv_minus_q;
    duty_d      = duty_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    calc_d      = (state_q == ST_ISSUE);
    drop_d      = i_sample_valid && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (i_sample_valid) begin
          vpv_d   = i_Vpv;
          ipv_d   = i_Ipv;
          vout_d  = i_Vout;
          state_d = ST_COMP;
        end
      end
      ST_COMP: begin
        ap_d    = ONE - dp;
        am_d    = ONE - dm;
        state_d = ST_MULT;
      end
      ST_MULT: begin
        pp_d    = mul_p[0];
        pm_d    = mul_p[1];
        state_d = ST_SUB;
      end
      ST_SUB: begin
        ep_d    = vpv_q - pp_q;
        em_d    = vpv_q - pm_q;
        state_d = ST_SCALE;
      end
      ST_SCALE: begin
        ipv_plus_d  = ipv_q + mul_p[2];
        ipv_minus_d = ipv_q + mul_p[3];
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the last counted cycle still wins over timeout.
        if (i_DV) begin
          duty_d  = clamp_duty(i_DC_control);
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      vpv_q       <= '0;
      ipv_q       <= '0;
      vout_q      <= '0;
      ap_q        <= '0;
      am_q        <= '0;
      pp_q        <= '0;
      pm_q        <= '0;
      ep_q        <= '0;
      em_q        <= '0;
      ipv_plus_q  <= '0;
      ipv_minus_q <= '0;
      duty_q      <= DUTY_INIT;
      calc_q      <= 1'b0;
      drop_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      vpv_q       <= vpv_d;
      ipv_q       <= ipv_d;
      vout_q      <= vout_d;
      ap_q        <= ap_d;
      am_q        <= am_d;
      pp_q        <= pp_d;
      pm_q        <= pm_d;
      ep_q        <= ep_d;
      em_q        <= em_d;
      ipv_plus_q  <= ipv_plus_d;
      ipv_minus_q <= ipv_minus_d;
      duty_q      <= duty_d;
      calc_q      <= calc_d;
      drop_q      <= drop_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_Vpv       = vpv_q;
  assign o_Ipv       = ipv_q;
  assign o_Vout      = vout_q;
  assign o_Ipv_plus  = ipv_plus_q;
  assign o_Ipv_minus = ipv_minus_q;
  assign o_calc_DV   = calc_q;
  assign o_duty      = duty_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_drop      = drop_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_mpc_boost_predictor.sv
// Self-checking bench: cycle-count behavioural model compared every cycle,
// plus hand-computed literal checks on the directed scenarios.
module tb_mpc_boost_predictor;

  localparam int    TO   = 64;
  localparam longint TSL = 655;
  localparam longint DCZ = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sv = 1'b0;
  logic dv = 1'b0;
  logic signed [31:0] vpv = '0, ipv = '0, vout = '0, dcc = '0;

  logic signed [31:0] o_Vpv, o_Ipv, o_Vout, o_Ipv_plus, o_Ipv_minus, o_duty;
  logic o_calc_DV, o_busy, o_drop, o_timeout;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  mpc_boost_predictor dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample_valid (sv),
    .i_Vpv          (vpv),
    .i_Ipv          (ipv),
    .i_Vout         (vout),
    .o_Vpv          (o_Vpv),
    .o_Ipv          (o_Ipv),
    .o_Vout         (o_Vout),
    .o_Ipv_plus     (o_Ipv_plus),
    .o_Ipv_minus    (o_Ipv_minus),
    .o_calc_DV      (o_calc_DV),
    .i_DC_control   (dcc),
    .i_DV           (dv),
    .o_duty         (o_duty),
    .o_busy         (o_busy),
    .o_drop         (o_drop),
    .o_timeout      (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] clamp(input logic [31:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = 0;
    if (v > 65536) v = 65536;
    return 32'(v);
  endfunction

  function automatic logic [31:0] predict(input logic [31:0] duty, input logic [31:0] v_pv,
                                          input logic [31:0] i_pv, input logic [31:0] v_out,
                                          input bit plus);
    longint d, a;
    int p, e, dl;
    d = plus ? longint'($signed(duty)) + DCZ : longint'($signed(duty)) - DCZ;
    if (d > 65536) d = 65536;
    if (d < 0) d = 0;
    a  = 65536 - d;
    p  = int'((a * longint'($signed(v_out))) >>> 16);
    e  = $signed(v_pv) - p;
    dl = int'((TSL * longint'(e)) >>> 16);
    return 32'($signed(i_pv) + dl);
  endfunction

  // m_k: 0 when idle, otherwise the cycle index since the accepted strobe.
  int m_k;
  logic [31:0] m_duty, m_vpv, m_ipv, m_vout, m_ip, m_im;
  logic m_calc, m_drop, m_timeout;

  task automatic m_reset();
    m_k = 0; m_duty = 32'h00008000;
    m_vpv = '0; m_ipv = '0; m_vout = '0; m_ip = '0; m_im = '0;
    m_calc = 1'b0; m_drop = 1'b0; m_timeout = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        m_drop = 1'b0;
        m_calc = 1'b0;
        if (m_k == 0) begin
          if (sv) begin
            m_vpv = vpv; m_ipv = ipv; m_vout = vout; m_k = 1;
          end
        end else begin
          if (sv) m_drop = 1'b1;
          if (m_k >= 6 && dv) begin
            m_duty = clamp(dcc); m_k = 0;
          end else if (m_k == 5 + TO) begin
            m_timeout = 1'b1; m_k = 0;
          end else begin
            m_k++;
            if (m_k == 5) begin
              m_ip = predict(m_duty, m_vpv, m_ipv, m_vout, 1'b1);
              m_im = predict(m_duty, m_vpv, m_ipv, m_vout, 1'b0);
            end
            if (m_k == 6) m_calc = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy",      32'(o_busy),    32'(m_k != 0));
        check("calc_DV",   32'(o_calc_DV), 32'(m_calc));
        check("drop",      32'(o_drop),    32'(m_drop));
        check("timeout",   32'(o_timeout), 32'(m_timeout));
        check("duty",      o_duty,         m_duty);
        check("Vpv",       o_Vpv,          m_vpv);
        check("Ipv",       o_Ipv,          m_ipv);
        check("Vout",      o_Vout,         m_vout);
        check("Ipv_plus",  o_Ipv_plus,     m_ip);
        check("Ipv_minus", o_Ipv_minus,    m_im);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_sample(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(posedge clk); #1;
    sv = 1'b1; vpv = a; ipv = b; vout = c;
  endtask

  task automatic wait_calc(output int lat);
    lat = -1;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (o_calc_DV === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
      sv = 1'b0;
    end
    sv = 1'b0;
  endtask

  task automatic respond(input int gap, input logic [31:0] dc);
    repeat (gap) @(posedge clk);
    #1; dv = 1'b1; dcc = dc;
    @(posedge clk); #1; dv = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int tl;
    int drop_cnt;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_duty",    o_duty,           32'h00008000);
    check("reset_busy",    32'(o_busy),      32'd0);
    check("reset_calc",    32'(o_calc_DV),   32'd0);
    check("reset_timeout", 32'(o_timeout),   32'd0);
    $display("txn reset: duty=%h busy=%0d", o_duty, o_busy);

    // Nominal prediction at duty 0.5.
    send_sample(32'h00230000, 32'h00050000, 32'h00500000);
    wait_calc(lat);
    check("nominal_latency",  32'(lat),    32'd6);
    check("nominal_plus",     o_Ipv_plus,  32'h0004F33A);
    check("nominal_minus",    o_Ipv_minus, 32'h0004F32F);
    respond(12, 32'h00008007);
    check("hs_duty",  o_duty,      32'h00008007);
    check("hs_busy",  32'(o_busy), 32'd0);
    $display("txn nominal: lat=%0d plus=%h minus=%h duty=%h", lat, o_Ipv_plus, o_Ipv_minus, o_duty);

    // Controller returns a duty above one.
    send_sample(32'h001E0000, 32'h00040000, 32'h003C0000);
    wait_calc(lat);
    respond(12, 32'h00012000);
    check("clamp_high_duty", o_duty, 32'h00010000);
    $display("txn clamp_high: duty=%h", o_duty);

    // Upper duty bound: Dp saturates at one.
    send_sample(32'h00230000, 32'h00050000, 32'h00500000);
    wait_calc(lat);
    check("upper_plus",  o_Ipv_plus,  32'd350605);
    check("upper_minus", o_Ipv_minus, 32'd350599);
    respond(5, 32'hFFFFF000);
    check("clamp_low_duty", o_duty, 32'h00000000);
    $display("txn upper: plus=%h minus=%h duty=%h", o_Ipv_plus, o_Ipv_minus, o_duty);

    // Lower duty bound (Dm saturates at zero), checked by the model.
    send_sample(32'h00140000, 32'h00030000, 32'h00280000);
    wait_calc(lat);
    respond(8, 32'h00008000);
    check("restore_duty", o_duty, 32'h00008000);
    $display("txn lower: plus=%h minus=%h duty=%h", o_Ipv_plus, o_Ipv_minus, o_duty);

    // Second strobe three cycles after the first is dropped.
    drop_cnt = 0;
    for (int n = 0; n <= 6; n++) begin
      @(posedge clk); #1;
      sv = (n == 0 || n == 3);
      if (n == 0) begin vpv = 32'h00230000; ipv = 32'h00050000; vout = 32'h00500000; end
      if (n == 3) begin vpv = 32'h00100000; ipv = 32'h00010000; vout = 32'h00200000; end
      @(negedge clk);
      if (o_drop === 1'b1) drop_cnt++;
    end
    check("drop_count",  32'(drop_cnt),   32'd1);
    check("drop_calc",   32'(o_calc_DV),  32'd1);
    check("drop_plus",   o_Ipv_plus,      32'h0004F33A);
    check("drop_minus",  o_Ipv_minus,     32'h0004F32F);
    respond(12, 32'h00008000);
    $display("txn drop: drops=%0d plus=%h", drop_cnt, o_Ipv_plus);

    // No response: timeout after TO cycles, duty untouched.
    send_sample(32'h00230000, 32'h00050000, 32'h00500000);
    wait_calc(lat);
    tl = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (o_timeout === 1'b1) begin
        tl = n;
        break;
      end
    end
    check("timeout_delay", 32'(tl),      32'd64);
    check("timeout_duty",  o_duty,       32'h00008000);
    check("timeout_busy",  32'(o_busy),  32'd0);
    $display("txn timeout: delay=%0d duty=%h", tl, o_duty);

    // Next sample is still processed; timeout stays sticky.
    send_sample(32'h00190000, 32'h00020000, 32'h00320000);
    wait_calc(lat);
    check("post_to_latency", 32'(lat), 32'd6);
    respond(10, 32'h00009000);
    check("post_to_duty",    o_duty,          32'h00009000);
    check("post_to_sticky",  32'(o_timeout),  32'd1);
    $display("txn after_timeout: duty=%h timeout=%0d", o_duty, o_timeout);

    // Asynchronous reset in the middle of WAIT.
    send_sample(32'h00230000, 32'h00050000, 32'h00500000);
    wait_calc(lat);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_timeout", 32'(o_timeout), 32'd0);
    check("arst_busy",    32'(o_busy),    32'd0);
    check("arst_calc",    32'(o_calc_DV), 32'd0);
    check("arst_duty",    o_duty,         32'h00008000);
    $display("txn async_reset: busy=%0d timeout=%0d duty=%h", o_busy, o_timeout, o_duty);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
